// File: rtl/multiplicador_secuencial_4bits_pkg.sv
// Shared types and constants for the 4x4 sequential shift-and-add multiplier.
package multiplicador_pkg;

  localparam int PASOS      = 4;
  localparam int ANCHO_OP   = 4;
  localparam int ANCHO_PROD = 8;

  typedef enum logic [1:0] {
    REPOSO  = 2'b00,
    CALCULA = 2'b01,
    FIN     = 2'b10
  } estado_t;

endpackage

// File: rtl/multiplicador_secuencial_4bits_if.sv
// Operand/result bus of the sequential multiplier.
// The master drives the start request and operands.
// The slave returns the product and the status flags.
interface multiplicador_secuencial_4bits_if;
  import multiplicador_pkg::*;

  logic                  inicio;
  logic [ANCHO_OP-1:0]   A;
  logic [ANCHO_OP-1:0]   B;
  logic [ANCHO_PROD-1:0] producto;
  logic                  listo;
  logic                  ocupado;

  modport master (
    output inicio, A, B,
    input  producto, listo, ocupado
  );

  modport slave (
    input  inicio, A, B,
    output producto, listo, ocupado
  );

endinterface

// File: rtl/multiplicador_secuencial_4bits_sumador.sv
// 4-bit unsigned ripple adder.
// It exposes its carry-out so that callers can keep the full 5-bit sum.
module Sumador4_Bits (
  input  logic [3:0] X,
  input  logic [3:0] Y,
  output logic [3:0] Salida,
  output logic       CarriSalida
);

  assign {CarriSalida, Salida} = {1'b0, X} + {1'b0, Y};

endmodule

// File: rtl/multiplicador_secuencial_4bits.sv
// Sequential 4x4 unsigned multiplier, one shift-and-add step per clock.
// The high half of P accumulates partial products.
// The low half of P holds the multiplier bits not yet consumed.
module multiplicador_secuencial_4bits
  import multiplicador_pkg::*;
(
  input  logic                                  clk,
  input  logic                                  rst_n,
  multiplicador_secuencial_4bits_if.slave       bus
);

  estado_t               estado;
  estado_t               estado_sig;

  logic [ANCHO_OP-1:0]   m;
  logic [ANCHO_PROD-1:0] p;
  logic [1:0]            cnt;
  logic [ANCHO_PROD-1:0] producto_q;

  logic                  carga;
  logic                  paso;
  logic                  ultimo;

  logic [ANCHO_OP-1:0]   suma;
  logic                  acarreo;
  logic [ANCHO_OP-1:0]   s_sel;
  logic                  c_sel;
  logic [ANCHO_PROD-1:0] p_sig;

  // The adder always sees M; a zero multiplier bit selects the unchanged accumulator instead.
  Sumador4_Bits u_sumador (
    .X           (p[7:4]),
    .Y           (m),
    .Salida      (suma),
    .CarriSalida (acarreo)
  );

  // Choose the partial sum, then shift right with the carry landing in bit 7.
  always_comb begin
    c_sel = 1'b0;
    s_sel = p[7:4];
    if (p[0]) begin
      c_sel = acarreo;
      s_sel = suma;
    end
    p_sig = {c_sel, s_sel, p[3:1]};
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado <= REPOSO;
    end else begin
      estado <= estado_sig;
    end
  end

  // Next-state logic and the load/step controls; a start request is honoured only in REPOSO.
  always_comb begin
    estado_sig = estado;
    carga      = 1'b0;
    paso       = 1'b0;
    ultimo     = 1'b0;
    case (estado)
      REPOSO: begin
        if (bus.inicio) begin
          carga      = 1'b1;
          estado_sig = CALCULA;
        end
      end
      CALCULA: begin
        paso = 1'b1;
        if (cnt == 2'(PASOS - 1)) begin
          ultimo     = 1'b1;
          estado_sig = FIN;
        end
      end
      FIN: begin
        estado_sig = REPOSO;
      end
      default: begin
        estado_sig = REPOSO;
      end
    endcase
  end

  // Operand capture, shift register, step counter and the result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m          <= '0;
      p          <= '0;
      cnt        <= '0;
      producto_q <= '0;
    end else if (carga) begin
      m   <= bus.A;
      p   <= {{(ANCHO_PROD - ANCHO_OP){1'b0}}, bus.B};
      cnt <= '0;
    end else if (paso) begin
      p   <= p_sig;
      cnt <= cnt + 2'd1;
      if (ultimo) begin
        producto_q <= p_sig;
      end
    end
  end

  assign bus.producto = producto_q;
  assign bus.listo    = (estado == FIN);
  assign bus.ocupado  = (estado != REPOSO);

endmodule

// File: tb/tb_multiplicador_secuencial_4bits.sv
// Directed bench for the sequential 4x4 multiplier.
// Expected products, latencies and strobe counts are hand-computed.
module tb_multiplicador_secuencial_4bits;

  logic clk;
  logic rst_n;

  int checks;
  int errors;
  logic [7:0] ultimo;

  int lat;
  int busy;
  int listos;
  int n;
  int l1, l2, l3;

  multiplicador_secuencial_4bits_if bus ();

  multiplicador_secuencial_4bits dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  // One full operation: a single start pulse, then tracking until ocupado falls.
  task automatic apply_stimulus(input logic [3:0] a, input logic [3:0] b, input logic [7:0] exp, input string tag);
    logic [7:0] antes;
    bus.A      = a;
    bus.B      = b;
    bus.inicio = 1'b1;
    tick();
    bus.inicio = 1'b0;
    bus.A      = ~a;
    bus.B      = ~b;
    busy   = 0;
    listos = 0;
    lat    = -1;
    n      = 0;
    antes  = 8'hxx;
    while (bus.ocupado && n < 12) begin
      busy++;
      if (bus.listo) begin
        if (lat < 0) lat = n;
        listos++;
      end
      if (n == 3) antes = bus.producto;
      tick();
      n++;
    end
    check_output({tag, " hold"},    16'(antes), 16'(ultimo));
    check_output({tag, " latency"}, 16'(lat), 16'd4);
    check_output({tag, " busy"},    16'(busy), 16'd5);
    check_output({tag, " listo"},   16'(listos), 16'd1);
    check_output({tag, " product"}, 16'(bus.producto), 16'(exp));
    ultimo = exp;
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    ultimo     = 8'h00;
    rst_n      = 1'b0;
    bus.inicio = 1'b0;
    bus.A      = 4'd0;
    bus.B      = 4'd0;
    tick();
    tick();
    check_output("reset producto", 16'(bus.producto), 16'h0000);
    check_output("reset listo",    16'(bus.listo),    16'h0000);
    check_output("reset ocupado",  16'(bus.ocupado),  16'h0000);
    rst_n = 1'b1;
    tick();
    check_output("idle ocupado", 16'(bus.ocupado), 16'h0000);

    $display("[TB] zero operands and carry cases");
    apply_stimulus(4'd0,  4'd0,  8'd0,   "0x0");
    apply_stimulus(4'd15, 4'd15, 8'hE1,  "15x15");
    apply_stimulus(4'd13, 4'd11, 8'h8F,  "13x11");

    $display("[TB] operand change and ignored start while busy");
    bus.A      = 4'd6;
    bus.B      = 4'd7;
    bus.inicio = 1'b1;
    tick();
    bus.inicio = 1'b0;
    tick();
    bus.A      = 4'd1;
    bus.B      = 4'd1;
    bus.inicio = 1'b1;
    tick();
    bus.inicio = 1'b0;
    listos = 0;
    n      = 0;
    while (bus.ocupado && n < 12) begin
      if (bus.listo) listos++;
      tick();
      n++;
    end
    check_output("busy-start listo count", 16'(listos), 16'd1);
    check_output("busy-start product",     16'(bus.producto), 16'd42);
    busy = 0;
    for (int k = 0; k < 4; k++) begin
      if (bus.ocupado) busy++;
      tick();
    end
    check_output("busy-start no restart", 16'(busy), 16'd0);
    ultimo = 8'd42;

    $display("[TB] reset in the middle of an operation");
    bus.A      = 4'd9;
    bus.B      = 4'd9;
    bus.inicio = 1'b1;
    tick();
    bus.inicio = 1'b0;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_output("abort producto", 16'(bus.producto), 16'h0000);
    check_output("abort listo",    16'(bus.listo),    16'h0000);
    check_output("abort ocupado",  16'(bus.ocupado),  16'h0000);
    listos = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (bus.listo) listos++;
    end
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (bus.listo || bus.ocupado) listos++;
    end
    check_output("abort no listo", 16'(listos), 16'd0);
    ultimo = 8'h00;
    apply_stimulus(4'd3, 4'd5, 8'd15, "3x5 after reset");

    $display("[TB] start held high");
    bus.A      = 4'd2;
    bus.B      = 4'd3;
    bus.inicio = 1'b1;
    tick();
    l1     = -1;
    l2     = -1;
    l3     = -1;
    listos = 0;
    for (int k = 0; k < 18; k++) begin
      if (bus.listo) begin
        listos++;
        if (l1 < 0) l1 = k;
        else if (l2 < 0) l2 = k;
        else if (l3 < 0) l3 = k;
        check_output("held product", 16'(bus.producto), 16'd6);
      end
      if (k == 17) bus.inicio = 1'b0;
      tick();
    end
    check_output("held listo count", 16'(listos), 16'd3);
    check_output("held first listo",  16'(l1), 16'd4);
    check_output("held second listo", 16'(l2), 16'd10);
    check_output("held third listo",  16'(l3), 16'd16);
    check_output("held drained", 16'(bus.ocupado), 16'd0);
    ultimo = 8'd6;

    $display("[TB] all operand pairs");
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        apply_stimulus(4'(i), 4'(j), 8'(i * j), $sformatf("%0dx%0d", i, j));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multiplicador_secuencial_4bits.md
# multiplicador_secuencial_4bits

Sequential shift-and-add 4x4 unsigned multiplier, built directly downstream of `Sumador4_Bits`: it consumes that adder's `Salida` and `CarriSalida` once per cycle to accumulate partial products.
- A start pulse loads two 4-bit operands.
- Four iterations then produce an 8-bit product.
- A one-cycle `listo` strobe flags the result.

It is the first clocked arithmetic block in the basic set and the natural consumer of the 4-bit adder.

## Interface

- Parameters: none. Widths are fixed: 4-bit operands, 8-bit product, 4 iterations.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `inicio` input 1: start request. Sampled only in REPOSO.
- `A` input 4: multiplicand. Captured on the accepting edge only.
- `B` input 4: multiplier. Captured on the accepting edge only.
- `producto` output 8: unsigned A*B. Registered; holds the last result.
- `listo` output 1: one-cycle strobe; `producto` is valid and new.
- `ocupado` output 1: high whenever state is not REPOSO.

## Operation

- Internal registers: `M[3:0]` (multiplicand), `P[7:0]` (high half = accumulator, low half = remaining multiplier bits), 2-bit step counter `cnt`, state.
- FSM states: REPOSO, CALCULA, FIN.
  - REPOSO, `inicio`=1: load `M`=A, `P`={4'b0,B}, `cnt`=0, go to CALCULA.
  - REPOSO, `inicio`=0: stay.
  - CALCULA: one step per cycle.
    - If `P[0]`=1: {c,s} = `P[7:4]` + `M` via `Sumador4_Bits`.
    - Else: {c,s} = {0,`P[7:4]`}.
    - Update `P` <= {c, s, `P[3:1]`} and `cnt` <= `cnt`+1.
    - When `cnt`==3 (fourth step), also load `producto` with the new `P` value and go to FIN.
  - FIN: `listo`=1 for exactly this cycle; next edge goes to REPOSO unconditionally.
- Arithmetic: the adder carry is never dropped. It becomes `P[7]` after the shift, so 15*15=225 fits exactly in 8 bits.
- `inicio` is ignored in CALCULA and FIN; no queuing.
- `A`/`B` changes after the accepting edge have no effect on the running operation.
- `producto` changes only on the edge entering FIN. Between operations it holds the previous result.
- Reset values: state=REPOSO, `producto`=8'h00, `listo`=0, `ocupado`=0; `P`, `M`, `cnt` = 0.
- Reset asserted mid-operation: immediate abort. No `listo`. `producto` returns to 0.

## Timing

- Edge E0: `inicio` sampled high in REPOSO. `ocupado` rises after E0.
- Edges E1–E4: the four iterations. `producto` is updated at E4.
- Cycle between E4 and E5: `listo`=1, `ocupado`=1.
- Edge E5: return to REPOSO. `listo` and `ocupado` fall.
- Latency from the accepting edge to `listo` high: 4 cycles.
- Minimum start-to-start spacing with `inicio` held high: 6 cycles (restart at E6).
- The adder path is combinational within one cycle: `P[7:4]` + `M` → `P` register.

## Structure

- Shared package `multiplicador_pkg`:
  - State encoding: REPOSO=2'b00, CALCULA=2'b01, FIN=2'b10.
  - Constants PASOS=4, ANCHO_OP=4, ANCHO_PROD=8.
- One sub-module: an instance of the existing `Sumador4_Bits`, with X=`P[7:4]` and Y=`M`.
  - The `P[0]`=0 case is handled by muxing the adder result, not by zeroing Y.
- FSM, counter and shift register are in the top module. Target size is about 150 lines.

## Test plan

- Reset, then A=0, B=0, single `inicio` pulse → `listo` 4 cycles after the accepting edge; `producto`=8'h00; `ocupado` high for exactly 5 cycles.
- A=15, B=15 → `producto`=225 (8'hE1), exercising carry into bit 7. Then A=13, B=11 → 143 (8'h8F).
- Start A=6, B=7; change A=1, B=1 and pulse `inicio` on E2 → `producto`=42, no second start, exactly one `listo`.
- Start A=9, B=9; drop `rst_n` between E2 and E3 → outputs 0 immediately, no `listo`. After release, A=3, B=5 → 15.
- `inicio` held high with A=2, B=3 → `listo` strobes every 6 cycles, `producto`=6 each time.
- Exhaustive: nested loops i, j = 0..15, one operation per pair → `producto`==i*j for all 256 pairs.
